// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction sequencer placed in front of simple_cpu. Holds a loadable
// program memory and a program counter. On start it walks the memory from
// address 0, fetching one word per FETCH cycle and holding it on the CPU
// instruction bus for a fixed dwell that depends on the opcode class (the CPU
// has no completion handshake). Execution ends on an all-zero HALT word or
// after the last memory address has been issued.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          synchronous active-high reset (program memory is retained)
//   prog_we      program memory write strobe, honoured only while idle
//   prog_addr    program write address
//   prog_data    program write data
//   start        single-cycle pulse, begins execution at address 0 (idle only)
//   instruction  word driven to the CPU; zero whenever not issuing
//   pc           address of the word being fetched or issued
//   busy         high while fetching or issuing
//   done         one-cycle pulse when execution ends
//   icount       (IFU_ICOUNT_EN only) instructions issued since start/rst,
//                saturating at 16'hFFFF
//
// Optional feature macro: IFU_ICOUNT_EN
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int INSTR_WIDTH  = 20,
  parameter int ADDR_BITS    = 5,
  parameter int ALU_CYCLES   = 4,
  parameter int LOAD_CYCLES  = 4,
  parameter int STORE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   start,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   done
`ifdef IFU_ICOUNT_EN
  ,
  output logic [15:0]            icount
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;

  localparam int MEM_DEPTH = 1 << ADDR_BITS;
  localparam int MAX_AL    = (ALU_CYCLES > LOAD_CYCLES) ? ALU_CYCLES : LOAD_CYCLES;
  localparam int MAX_DWELL = (MAX_AL > STORE_CYCLES) ? MAX_AL : STORE_CYCLES;
  localparam int CNT_W     = $clog2(MAX_DWELL + 1);

  localparam logic [ADDR_BITS-1:0] LAST_ADDR = {ADDR_BITS{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);

  logic [1:0]             state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
`ifdef IFU_ICOUNT_EN
  logic [15:0]            icount_q, icount_d;
`endif

  // Program memory with a registered read port.
  logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];
  logic [INSTR_WIDTH-1:0] mem_rd_q;
  logic                   wr_en;
  logic                   byp_hit_q, byp_hit_d;
  logic [INSTR_WIDTH-1:0] byp_data_q, byp_data_d;
  logic [INSTR_WIDTH-1:0] fetched;
  logic [CNT_W-1:0]       dwell;

  assign wr_en = (state_q == S_IDLE) && prog_we;

  // The read address is the next-cycle pc, so the word for a FETCH cycle is
  // already registered when that cycle begins. A write landing on the same
  // address in the same cycle (start together with prog_we) is forwarded so
  // the freshly written word is the one fetched.
  always_comb begin
    byp_hit_d  = wr_en && (prog_addr == pc_d);
    byp_data_d = prog_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[prog_addr] <= prog_data;
    end
    mem_rd_q <= mem[pc_d];
  end

  always_ff @(posedge clk) begin
    byp_hit_q  <= byp_hit_d;
    byp_data_q <= byp_data_d;
  end

  assign fetched = byp_hit_q ? byp_data_q : mem_rd_q;

  // Dwell per opcode class; a non-zero class-00 word is held for one cycle.
  always_comb begin
    dwell = CNT_ONE;
    case (fetched[INSTR_WIDTH-1 -: 2])
      2'b01:   dwell = CNT_W'(ALU_CYCLES);
      2'b10:   dwell = CNT_W'(LOAD_CYCLES);
      2'b11:   dwell = CNT_W'(STORE_CYCLES);
      default: dwell = CNT_ONE;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef IFU_ICOUNT_EN
    icount_d = icount_q;
`endif
    case (state_q)
      S_IDLE: begin
        instr_d = '0;
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
`ifdef IFU_ICOUNT_EN
          icount_d = 16'd0;
`endif
        end
      end
      S_FETCH: begin
        if (fetched == '0) begin
          // HALT word: never placed on the bus.
          instr_d = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          instr_d = fetched;
          cnt_d   = dwell;
          state_d = S_ISSUE;
`ifdef IFU_ICOUNT_EN
          if (icount_q != 16'hFFFF) begin
            icount_d = icount_q + 16'd1;
          end
`endif
        end
      end
      S_ISSUE: begin
        if (cnt_q == CNT_ONE) begin
          instr_d = '0;
          if (pc_q == LAST_ADDR) begin
            // End of memory: stop without wrapping the pc.
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        instr_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef IFU_ICOUNT_EN
      icount_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef IFU_ICOUNT_EN
      icount_q <= icount_d;
`endif
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef IFU_ICOUNT_EN
  assign icount      = icount_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed self-checking bench for instr_fetch_unit. Inputs are driven and
// outputs sampled 1 time unit after each rising edge. Covers reset values,
// a two-instruction run ending on HALT, inputs ignored while busy, reset in
// the middle of a run, a full-memory run that stops at the last address, and
// a HALT at address 0 written in the same cycle as start.
// Honours IFU_ICOUNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [19:0] W0 = 20'b01000111000000000000;
  localparam logic [19:0] W1 = 20'b11011000000011110000;
  localparam logic [19:0] WL = 20'b10111000000011110000;

  logic        clk;
  logic        rst;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [19:0] prog_data;
  logic        start;
  logic [19:0] instruction;
  logic [4:0]  pc;
  logic        busy;
  logic        done;
`ifdef IFU_ICOUNT_EN
  logic [15:0] icount;
`endif

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .start       (start),
    .instruction (instruction),
    .pc          (pc),
    .busy        (busy),
    .done        (done)
`ifdef IFU_ICOUNT_EN
    ,
    .icount      (icount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Expected per-cycle trace of the basic program, sample 0 being the FETCH
  // cycle right after the start edge.
  logic [19:0] exp_ins  [12];
  logic        exp_busy [12];
  logic        exp_done [12];
  logic [4:0]  exp_pc   [12];

  int          issues;
  int          dones;
  int          done_idx;
  int          wraps;
  int          bad_words;
  logic [19:0] prev_ins;
  logic        seen_nz_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [19:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    step();
    prog_we   = 1'b0;
  endtask

  // Runs the basic program and checks every cycle. At sample index inj the
  // bench tries to overwrite mem[1] and restart, which must have no effect.
  task automatic run_trace(input string name, input int inj);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("%s_ins%0d", name, i), 32'(instruction), 32'(exp_ins[i]));
      chk($sformatf("%s_busy%0d", name, i), 32'(busy), 32'(exp_busy[i]));
      chk($sformatf("%s_done%0d", name, i), 32'(done), 32'(exp_done[i]));
      chk($sformatf("%s_pc%0d", name, i), 32'(pc), 32'(exp_pc[i]));
      if (i == inj) begin
        prog_we   = 1'b1;
        prog_addr = 5'd1;
        prog_data = 20'hFFFFF;
        start     = 1'b1;
      end
      step();
      prog_we = 1'b0;
      start   = 1'b0;
    end
`ifdef IFU_ICOUNT_EN
    chk($sformatf("%s_icount", name), 32'(icount), 32'd2);
`endif
    $display("run %s complete, checks so far %0d", name, n_checks);
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;

    exp_ins  = '{20'd0, W0, W0, W0, W0, 20'd0, W1, W1, W1, 20'd0, 20'd0, 20'd0};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_pc   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd2, 5'd2, 5'd2};

    // Reset held for two cycles.
    step();
    step();
    chk("rst_ins", 32'(instruction), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef IFU_ICOUNT_EN
    chk("rst_icount", 32'(icount), 32'd0);
`endif
    rst = 1'b0;
    step();
    $display("reset sequence checked");

    // Basic program.
    load(5'd0, W0);
    load(5'd1, W1);
    load(5'd2, 20'd0);
    run_trace("basic", -1);

    // Write and restart attempted while issuing word0.
    run_trace("ignored", 2);
    run_trace("rerun", -1);

    // Reset during the first ISSUE.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("midrst_pre_ins", 32'(instruction), 32'(W0));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_ins", 32'(instruction), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_pc", 32'(pc), 32'd0);
`ifdef IFU_ICOUNT_EN
    chk("midrst_icount", 32'(icount), 32'd0);
`endif
    step();
    chk("midrst_done_after", 32'(done), 32'd0);
    chk("midrst_busy_after", 32'(busy), 32'd0);
    $display("reset mid-run checked");
    run_trace("replay", -1);

    // Full memory of LOAD words: 32 issues, stop at pc 31.
    for (int a = 0; a < 32; a++) begin
      load(5'(a), WL);
    end
    issues     = 0;
    dones      = 0;
    done_idx   = -1;
    wraps      = 0;
    bad_words  = 0;
    prev_ins   = '0;
    seen_nz_pc = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 180; i++) begin
      if (instruction != 20'd0 && prev_ins == 20'd0) issues++;
      if (instruction != 20'd0 && instruction != WL) bad_words++;
      if (done) begin
        dones++;
        if (done_idx < 0) done_idx = i;
      end
      if (pc != 5'd0) seen_nz_pc = 1'b1;
      else if (seen_nz_pc) wraps++;
      prev_ins = instruction;
      step();
    end
    chk("eom_issues", 32'(issues), 32'd32);
    chk("eom_dones", 32'(dones), 32'd1);
    chk("eom_done_idx", 32'(done_idx), 32'd160);
    chk("eom_wraps", 32'(wraps), 32'd0);
    chk("eom_bad_words", 32'(bad_words), 32'd0);
    chk("eom_pc", 32'(pc), 32'd31);
    chk("eom_busy", 32'(busy), 32'd0);
`ifdef IFU_ICOUNT_EN
    chk("eom_icount", 32'(icount), 32'd32);
`endif
    $display("end-of-memory run: issues %0d dones %0d done_idx %0d", issues, dones, done_idx);

    // HALT at address 0, written in the same cycle as start.
    prog_we   = 1'b1;
    prog_addr = 5'd0;
    prog_data = 20'd0;
    start     = 1'b1;
    step();
    prog_we = 1'b0;
    start   = 1'b0;
    chk("halt_fetch_busy", 32'(busy), 32'd1);
    chk("halt_fetch_ins", 32'(instruction), 32'd0);
    chk("halt_fetch_pc", 32'(pc), 32'd0);
    chk("halt_fetch_done", 32'(done), 32'd0);
    step();
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_busy", 32'(busy), 32'd0);
    chk("halt_ins", 32'(instruction), 32'd0);
`ifdef IFU_ICOUNT_EN
    chk("halt_icount", 32'(icount), 32'd0);
`endif
    step();
    chk("halt_done_after", 32'(done), 32'd0);
    chk("halt_ins_after", 32'(instruction), 32'd0);
    $display("halt-at-zero run checked");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
